// File: rtl/fetch_pkg.sv
// Shared types and sizing for the instruction fetch unit.
// Define FETCH_BUF2_EN for a two-entry fetch buffer; otherwise a single holding register.
package fetch_pkg;

  localparam int WIDTH = 32;

`ifdef FETCH_BUF2_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// DEPTH-entry fetch FIFO; head is always slot 0, pops shift the remaining entries down.
// Clear wins over a same-cycle push or pop.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  fetch_entry_t     push_data_i,
  input  logic             pop_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] count_o,
  output logic             head_valid_o,
  output fetch_entry_t     head_o
);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_pop;

  always_comb begin
    mem_d   = mem_q;
    cnt_pop = cnt_q;
    cnt_d   = cnt_q;
    if (pop_i && (cnt_q != '0)) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i + 1];
      end
      cnt_pop = cnt_q - CNT_W'(1);
    end
    cnt_d = cnt_pop;
    // The new entry lands just behind whatever survives this cycle's pop.
    if (push_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == cnt_pop) begin
          mem_d[i] = push_data_i;
        end
      end
      cnt_d = cnt_pop + CNT_W'(1);
    end
    if (clear_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

  assign count_o      = cnt_q;
  assign head_valid_o = (cnt_q != '0);
  assign head_o       = mem_q[0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: latches the PC, issues one req/ack memory request at a time,
// buffers returned words for the decoder and discards them on flush (see FETCH_BUF2_EN).
module fetch_unit
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_addr,
  output logic             pc_inc,
  input  logic             flush,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             instr_valid,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  input  logic             instr_ready,
  output logic [1:0]       dbg_state
);

  // Handshakes: mem_req/mem_addr stay asserted and stable until the cycle mem_ack=1;
  // the buffer head transfers to the decoder on any cycle with instr_valid & instr_ready.

  fetch_state_e     state_q;
  fetch_state_e     state_d;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] addr_d;

  logic             push;
  logic             pop;
  logic             has_room;
  logic [CNT_W-1:0] buf_count;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;

  assign has_room = (buf_count < CNT_W'(DEPTH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // A flush in IDLE blocks the latch so the stale PC is never fetched.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: begin
        if (has_room && !flush) begin
          addr_d  = pc_addr;
          state_d = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d = IDLE;
        end else if (flush) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req          = (state_q == REQ) || (state_q == DISCARD);
    mem_addr         = addr_q;
    push             = (state_q == REQ) && mem_ack && !flush;
    pc_inc           = push;
    push_entry.instr = mem_rdata;
    push_entry.pc    = addr_q;
  end

  assign pop = instr_valid && instr_ready;

  fetch_buf u_buf (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .push_data_i  (push_entry),
    .pop_i        (pop),
    .clear_i      (flush),
    .count_o      (buf_count),
    .head_valid_o (instr_valid),
    .head_o       (head)
  );

  assign instr     = head.instr;
  assign instr_pc  = head.pc;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, stall, flush while waiting, flush with ack+pop.
// Honours FETCH_BUF2_EN to pick the expected buffer depth.
module tb_fetch_unit;

`ifdef FETCH_BUF2_EN
  localparam int DEPTH_TB = 2;
`else
  localparam int DEPTH_TB = 1;
`endif
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_addr = '0;
  logic        pc_inc;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic [1:0]  dbg_state;

  logic        pc_load = 1'b0;
  logic [31:0] pc_load_val = '0;
  logic [31:0] flush_pc = '0;
  int          inc_cnt = 0;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .pc_addr     (pc_addr),
    .pc_inc      (pc_inc),
    .flush       (flush),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .dbg_state   (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Program counter model: load, redirect on flush, increment on pc_inc.
  always @(posedge clk) begin
    if (pc_load) pc_addr <= pc_load_val;
    else if (flush) pc_addr <= flush_pc;
    else if (pc_inc) pc_addr <= pc_addr + 32'd1;
    if (pc_inc) inc_cnt <= inc_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic do_reset(input logic [31:0] pc);
    reset       = 1'b1;
    flush       = 1'b0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
    pc_load     = 1'b1;
    pc_load_val = pc;
    repeat (2) @(negedge clk);
    pc_load = 1'b0;
    reset   = 1'b0;
  endtask

  task automatic wait_req(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bit got;
    instr_ready = 1'b1;
    reset = 1'b1; pc_load = 1'b1; pc_load_val = 32'h55;
    mem_ack = 1'b0; flush = 1'b0;
    @(negedge clk); @(negedge clk);
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_vec++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    n_vec++; if (pc_inc !== 1'b0) begin n_err++; $display("FAIL reset_pc_inc: got %b want 0", pc_inc); end
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
    n_vec++; if (instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", instr); end
    n_vec++; if (instr_pc !== 32'h0) begin n_err++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
    n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
    pc_load = 1'b0; reset = 1'b0;
    wait_req(6, got);
    n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL reset_first_req: got %b want 1", got); end
    n_vec++; if (mem_addr !== 32'h55) begin n_err++; $display("FAIL reset_first_addr: got %h want 55", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h1234;
    #1;
    n_vec++; if (pc_inc !== 1'b1) begin n_err++; $display("FAIL reset_pre_inc: got %b want 1", pc_inc); end
    reset = 1'b1;
    #1;
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mid_req: got %b want 0", mem_req); end
    n_vec++; if (pc_inc !== 1'b0) begin n_err++; $display("FAIL reset_mid_pc_inc: got %b want 0", pc_inc); end
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_mid_valid: got %b want 0", instr_valid); end
    mem_ack = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_release_state: got %0d want %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_streaming();
    bit got;
    int inc0;
    instr_ready = 1'b1;
    do_reset(32'h10);
    inc0 = inc_cnt;
    wait_req(6, got);
    n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL stream_req0: got %b want 1", got); end
    n_vec++; if (mem_addr !== 32'h10) begin n_err++; $display("FAIL stream_addr0: got %h want 10", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'hA0;
    #1;
    n_vec++; if (pc_inc !== 1'b1) begin n_err++; $display("FAIL stream_pc_inc: got %b want 1", pc_inc); end
    @(negedge clk);
    mem_ack = 1'b0;
    n_vec++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid: got %b want 1", instr_valid); end
    n_vec++; if (instr !== 32'hA0) begin n_err++; $display("FAIL stream_instr: got %h want a0", instr); end
    n_vec++; if (instr_pc !== 32'h10) begin n_err++; $display("FAIL stream_instr_pc: got %h want 10", instr_pc); end
    n_vec++; if (pc_inc !== 1'b0) begin n_err++; $display("FAIL stream_pc_inc_pulse: got %b want 0", pc_inc); end
    wait_req(8, got);
    n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL stream_req1: got %b want 1", got); end
    n_vec++; if (mem_addr !== 32'h11) begin n_err++; $display("FAIL stream_addr1: got %h want 11", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'hA1;
    @(negedge clk);
    mem_ack = 1'b0;
    n_vec++; if (instr_pc !== 32'h11) begin n_err++; $display("FAIL stream_instr_pc1: got %h want 11", instr_pc); end
    n_vec++; if (inc_cnt - inc0 !== 2) begin n_err++; $display("FAIL stream_inc_count: got %0d want 2", inc_cnt - inc0); end
  endtask

  task automatic test_stall();
    bit got;
    int n_fetch;
    logic [63:0] e;
    instr_ready = 1'b0;
    exp_q.delete();
    do_reset(32'h10);
    n_fetch = 0;
    for (int k = 0; k < 4; k++) begin
      wait_req(8, got);
      if (!got) break;
      n_vec++;
      if (mem_addr !== 32'h10 + 32'(n_fetch)) begin
        n_err++; $display("FAIL stall_addr%0d: got %h want %h", n_fetch, mem_addr, 32'h10 + 32'(n_fetch));
      end
      exp_q.push_back({32'hA0 + 32'(n_fetch), 32'h10 + 32'(n_fetch)});
      mem_ack = 1'b1; mem_rdata = 32'hA0 + 32'(n_fetch);
      @(negedge clk);
      mem_ack = 1'b0;
      n_fetch++;
    end
    n_vec++; if (n_fetch !== DEPTH_TB) begin n_err++; $display("FAIL stall_fetch_count: got %0d want %0d", n_fetch, DEPTH_TB); end
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL stall_no_req: got %b want 0", mem_req); end
    n_vec++; if (instr !== 32'hA0) begin n_err++; $display("FAIL stall_hold_instr: got %h want a0", instr); end
    n_vec++; if (instr_pc !== 32'h10) begin n_err++; $display("FAIL stall_hold_pc: got %h want 10", instr_pc); end
    instr_ready = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL stall_drain_valid: got %b want 1", instr_valid); end
      n_vec++; if ({instr, instr_pc} !== e) begin n_err++; $display("FAIL stall_drain_entry: got %h/%h want %h/%h", instr, instr_pc, e[63:32], e[31:0]); end
      @(negedge clk);
    end
    wait_req(8, got);
    n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL stall_resume: got %b want 1", got); end
    n_vec++; if (mem_addr !== 32'h10 + 32'(DEPTH_TB)) begin n_err++; $display("FAIL stall_resume_addr: got %h want %h", mem_addr, 32'h10 + 32'(DEPTH_TB)); end
    mem_ack = 1'b1; mem_rdata = 32'hEE;
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  task automatic test_flush_wait();
    bit got;
    int inc0;
    instr_ready = 1'b1;
    do_reset(32'h20);
    wait_req(6, got);
    n_vec++; if (mem_addr !== 32'h20) begin n_err++; $display("FAIL fwait_addr: got %h want 20", mem_addr); end
    inc0 = inc_cnt;
    flush = 1'b1; flush_pc = 32'h40;
    @(negedge clk);
    flush = 1'b0;
    n_vec++; if (dbg_state !== ST_DISCARD) begin n_err++; $display("FAIL fwait_state: got %0d want %0d", dbg_state, ST_DISCARD); end
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL fwait_req_held: got %b want 1", mem_req); end
    n_vec++; if (mem_addr !== 32'h20) begin n_err++; $display("FAIL fwait_addr_held: got %h want 20", mem_addr); end
    @(negedge clk);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD;
    #1;
    n_vec++; if (pc_inc !== 1'b0) begin n_err++; $display("FAIL fwait_pc_inc: got %b want 0", pc_inc); end
    @(negedge clk);
    mem_ack = 1'b0;
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL fwait_buf_empty: got %b want 0", instr_valid); end
    n_vec++; if (inc_cnt !== inc0) begin n_err++; $display("FAIL fwait_inc_count: got %0d want %0d", inc_cnt, inc0); end
    wait_req(6, got);
    n_vec++; if (mem_addr !== 32'h40) begin n_err++; $display("FAIL fwait_new_addr: got %h want 40", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'hB0;
    @(negedge clk);
    mem_ack = 1'b0;
    n_vec++; if ({instr, instr_pc} !== {32'hB0, 32'h40}) begin n_err++; $display("FAIL fwait_new_entry: got %h/%h want b0/40", instr, instr_pc); end
  endtask

  task automatic test_flush_ack_pop();
    bit got;
    int inc0;
    do_reset(32'h30);
`ifdef FETCH_BUF2_EN
    instr_ready = 1'b0;
    wait_req(6, got);
    mem_ack = 1'b1; mem_rdata = 32'hC0;
    @(negedge clk);
    mem_ack = 1'b0;
    wait_req(6, got);
    n_vec++; if (mem_addr !== 32'h31) begin n_err++; $display("FAIL fap_addr: got %h want 31", mem_addr); end
    n_vec++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL fap_prefill: got %b want 1", instr_valid); end
`else
    instr_ready = 1'b1;
    wait_req(6, got);
    n_vec++; if (mem_addr !== 32'h30) begin n_err++; $display("FAIL fap_addr: got %h want 30", mem_addr); end
`endif
    inc0 = inc_cnt;
    mem_ack = 1'b1; mem_rdata = 32'hC1;
    flush = 1'b1; flush_pc = 32'h80;
    instr_ready = 1'b1;
    #1;
    n_vec++; if (pc_inc !== 1'b0) begin n_err++; $display("FAIL fap_pc_inc: got %b want 0", pc_inc); end
    @(negedge clk);
    mem_ack = 1'b0; flush = 1'b0;
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL fap_valid: got %b want 0", instr_valid); end
    n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL fap_state: got %0d want %0d", dbg_state, ST_IDLE); end
    n_vec++; if (inc_cnt !== inc0) begin n_err++; $display("FAIL fap_inc_count: got %0d want %0d", inc_cnt, inc0); end
    wait_req(6, got);
    n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL fap_next_req: got %b want 1", got); end
    n_vec++; if (mem_addr !== 32'h80) begin n_err++; $display("FAIL fap_next_addr: got %h want 80", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'hD0;
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_flush_wait();
    test_flush_ack_pop();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
